// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - timed, selectable 8-LED pattern sequencer
module led_pattern_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int REPEAT   = 3
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       run,
    input  logic       next,
    input  logic       auto,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WMAX = WW'(REPEAT - 1);

    typedef enum logic [1:0] {
        FILL_CLR = 2'd0,
        CHASE    = 2'd1,
        PINGPONG = 2'd2,
        BLINK    = 2'd3
    } mode_t;

    mode_t         state;
    mode_t         state_nx;
    logic          dir;       // 0 = moving left, 1 = moving right
    logic          dir_nx;
    logic          next_d;
    logic [PW-1:0] presc;
    logic [WW-1:0] wrap_cnt;
    logic [7:0]    led_nx;
    logic [7:0]    led_start;
    logic          wrap;
    logic          tick;
    logic          next_edge;
    logic          advance;

    assign mode      = state;
    assign next_edge = next & ~next_d;
    assign tick      = run & (presc == PMAX);
    assign advance   = next_edge | (tick & wrap & auto & (wrap_cnt == WMAX));
    assign state_nx  = mode_t'(state + 2'd1);
    assign led_start = (state_nx == CHASE || state_nx == PINGPONG) ? 8'h01 : 8'hFF;

    // Next pattern value and wrap flag for the current mode, used only on a tick.
    always_comb begin
        led_nx = led;
        dir_nx = dir;
        wrap   = 1'b0;
        case (state)
            FILL_CLR: begin
                if (led == 8'h00) begin
                    led_nx = 8'hFF;
                    wrap   = 1'b1;
                end else begin
                    led_nx = {led[6:0], 1'b0};
                end
            end
            CHASE: begin
                led_nx = {led[6:0], led[7]};
                wrap   = (led == 8'h80);
            end
            PINGPONG: begin
                if (!dir) begin
                    if (led == 8'h80) begin
                        led_nx = 8'h40;
                        dir_nx = 1'b1;
                    end else begin
                        led_nx = {led[6:0], 1'b0};
                    end
                end else begin
                    if (led == 8'h02) begin
                        led_nx = 8'h01;
                        dir_nx = 1'b0;
                        wrap   = 1'b1;
                    end else begin
                        led_nx = {1'b0, led[7:1]};
                    end
                end
            end
            BLINK: begin
                led_nx = ~led;
                wrap   = (led == 8'h00);
            end
            default: begin
                led_nx = led;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state    <= FILL_CLR;
            led      <= 8'hFF;
            dir      <= 1'b0;
            step     <= 1'b0;
            presc    <= '0;
            wrap_cnt <= '0;
            next_d   <= 1'b0;
        end else begin
            next_d <= next;
            if (advance) begin
                state    <= state_nx;
                led      <= led_start;
                dir      <= 1'b0;
                step     <= 1'b0;
                presc    <= '0;
                wrap_cnt <= '0;
            end else begin
                step <= tick;
                if (run) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
                if (tick) begin
                    led <= led_nx;
                    dir <= dir_nx;
                    // Without auto-advance the wrap count parks at its top value.
                    if (wrap && wrap_cnt != WMAX) begin
                        wrap_cnt <= wrap_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized bench with a pattern-table reference model
module tb_led_pattern_ctrl;
    logic       clk;
    logic       rs;
    logic       run;
    logic       next;
    logic       auto;
    logic [7:0] led  [3];
    logic [1:0] mode [3];
    logic       step [3];

    int vectors;
    int miscompares;
    bit cmp_en;

    // Instance k runs with TICK_DIV = TD[k], REPEAT = RP[k].
    int TD [3] = '{1, 2, 4};
    int RP [3] = '{2, 3, 3};

    led_pattern_ctrl #(.TICK_DIV(1), .REPEAT(2)) u0 (
        .clk(clk), .rs(rs), .run(run), .next(next), .auto(auto),
        .led(led[0]), .mode(mode[0]), .step(step[0]));
    led_pattern_ctrl #(.TICK_DIV(2), .REPEAT(3)) u1 (
        .clk(clk), .rs(rs), .run(run), .next(next), .auto(auto),
        .led(led[1]), .mode(mode[1]), .step(step[1]));
    led_pattern_ctrl #(.TICK_DIV(4), .REPEAT(3)) u2 (
        .clk(clk), .rs(rs), .run(run), .next(next), .auto(auto),
        .led(led[2]), .mode(mode[2]), .step(step[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each mode is a table of values indexed by position within its period.
    int m_phase [3];
    int m_pos   [3];
    int m_mode  [3];
    int m_wc    [3];
    bit m_step  [3];
    bit m_nd    [3];

    function automatic int period(input int m);
        case (m)
            0: return 9;
            1: return 8;
            2: return 14;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int m, input int p);
        logic [7:0] v;
        case (m)
            0: begin v = 8'hFF; v = v << p; end
            1: begin v = 8'h01; v = v << p; end
            2: begin v = 8'h01; v = (p < 8) ? (v << p) : (v << (14 - p)); end
            default: v = (p % 2 == 0) ? 8'hFF : 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_pos[k] = 0; m_mode[k] = 0;
            m_wc[k] = 0; m_step[k] = 0; m_nd[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit edge_, tick, wrapt, adv;
        edge_   = next && !m_nd[k];
        m_nd[k] = next;
        tick    = run && (m_phase[k] == TD[k] - 1);
        wrapt   = tick && (m_pos[k] == period(m_mode[k]) - 1);
        adv     = edge_ || (wrapt && auto && (m_wc[k] == RP[k] - 1));
        if (adv) begin
            m_mode[k]  = (m_mode[k] + 1) % 4;
            m_pos[k]   = 0;
            m_phase[k] = 0;
            m_wc[k]    = 0;
            m_step[k]  = 0;
        end else begin
            m_step[k] = tick;
            if (run) m_phase[k] = tick ? 0 : m_phase[k] + 1;
            if (tick) begin
                m_pos[k] = (m_pos[k] + 1) % period(m_mode[k]);
                if (wrapt && m_wc[k] < RP[k] - 1) m_wc[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rs) begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_u%0d led/mode/step", k),
                    {21'd0, led[k], mode[k], step[k]},
                    {21'd0, pat(m_mode[k], m_pos[k]), 2'(m_mode[k]), m_step[k]});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic rs_pulse();
        rs = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_reset_u%0d", k), {21'd0, led[k], mode[k], step[k]},
                {21'd0, 8'hFF, 2'd0, 1'b0});
        end
        cyc();
        cyc();
        rs = 1'b0;
    endtask

    logic [7:0] fill_exp [11] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0,
                                  8'hC0, 8'h80, 8'h00, 8'hFF, 8'hFE};
    logic [7:0] pp_exp [14]   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    initial begin
        int pulses;
        logic [7:0] v;
        vectors = 0; miscompares = 0; cmp_en = 0;
        rs = 1'b1; run = 1'b0; next = 1'b0; auto = 1'b0;
        model_reset();
        cyc();
        cyc();
        cmp_en = 1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_u%0d", k), {21'd0, led[k], mode[k], step[k]},
                {21'd0, 8'hFF, 2'd0, 1'b0});
        end

        // FILL_CLR at TICK_DIV=2: one step every second edge.
        rs = 1'b0; run = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            v = fill_exp[c / 2];
            chk($sformatf("fill_c%0d", c), {24'd0, led[1]}, {24'd0, v});
            if (step[1]) pulses++;
        end
        chk("fill_step_pulses", pulses, 10);

        // Pause with the TICK_DIV=4 prescaler at 2, then resume.
        rs_pulse();
        run = 1'b1;
        cyc();
        cyc();
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("pause_led", {24'd0, led[2]}, 32'hFF);
            chk("pause_step", {31'd0, step[2]}, 32'd0);
        end
        run = 1'b1;
        cyc();
        chk("resume_edge1", {24'd0, led[2]}, 32'hFF);
        cyc();
        chk("resume_edge2", {24'd0, led[2]}, 32'hFE);

        // next pulses on the TICK_DIV=1 instance.
        rs_pulse();
        run = 1'b1;
        cyc();
        cyc();
        next = 1'b1;
        cyc();
        next = 1'b0;
        chk("next_to_chase", {21'd0, led[0], mode[0], step[0]}, {21'd0, 8'h01, 2'd1, 1'b0});
        for (int c = 1; c <= 8; c++) begin
            cyc();
            v = 8'h01;
            v = v << (c % 8);
            chk($sformatf("chase_c%0d", c), {24'd0, led[0]}, {24'd0, v});
        end
        next = 1'b1;
        cyc();
        next = 1'b0;
        chk("next_to_pingpong", {22'd0, led[0], mode[0]}, {22'd0, 8'h01, 2'd2});
        for (int c = 0; c < 14; c++) begin
            cyc();
            v = pp_exp[c];
            chk($sformatf("pingpong_c%0d", c), {24'd0, led[0]}, {24'd0, v});
        end
        next = 1'b1;
        repeat (5) cyc();
        next = 1'b0;
        chk("held_next_once", {30'd0, mode[0]}, 32'd3);

        // Randomized phase; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            cyc();
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) next = ~next;
            if ($urandom_range(0, 149) == 0) auto = ~auto;
            if ($urandom_range(0, 599) == 0) rs_pulse();
        end

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
